mem_access: RTL and testbench

MEM-stage block between `ex_mem` and `mem_wb`. It drives the data-memory request/response bus and aligns load data, masks and replicates store data, and detects load/store address errors. It also raises `stall_req` so the stall controller holds the pipeline until the memory transaction completes. Its `o_*` outputs feed the matching `i_*` inputs of `mem_wb` one-for-one; `o_badvaddr` is the one addition.

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_access_load_align.sv | 65 ++++++
 rtl/mem_access.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared constants for the MEM stage: memory op codes,
//               exception bit indices and the zero word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;
    localparam logic [3:0] MEM_OP_LWL  = 4'd9;
    localparam logic [3:0] MEM_OP_LWR  = 4'd10;
    localparam logic [3:0] MEM_OP_SWL  = 4'd11;
    localparam logic [3:0] MEM_OP_SWR  = 4'd12;

    // Bit positions inside the 7-bit exception vector
    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/mem_access_load_align.sv
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load-data alignment. Selects the byte/half lane
//               from the raw memory word, applies sign/zero extension and,
//               when UNALIGNED_LR_EN is defined, merges LWL/LWR with rt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_raw,
    input  logic [31:0] i_rt,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

`ifndef UNALIGNED_LR_EN
    // rt only matters for the partial-word merges
    logic w_unused_rt;
    assign w_unused_rt = ^i_rt;
`endif

    // Lane select and extension per load type; non-loads return zero
    always_comb begin
        o_data = ZERO_WORD;
        case (i_op)
            MEM_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            MEM_OP_LBU: o_data = {24'h0, w_byte};
            MEM_OP_LH:  o_data = {{16{w_half[15]}}, w_half};
            MEM_OP_LHU: o_data = {16'h0, w_half};
            MEM_OP_LW:  o_data = i_raw;
`ifdef UNALIGNED_LR_EN
            MEM_OP_LWL: begin
                case (i_offset)
                    2'd0:    o_data = {i_raw[7:0],  i_rt[23:0]};
                    2'd1:    o_data = {i_raw[15:0], i_rt[15:0]};
                    2'd2:    o_data = {i_raw[23:0], i_rt[7:0]};
                    default: o_data = i_raw;
                endcase
            end
            MEM_OP_LWR: begin
                case (i_offset)
                    2'd0:    o_data = i_raw;
                    2'd1:    o_data = {i_rt[31:24], i_raw[31:8]};
                    2'd2:    o_data = {i_rt[31:16], i_raw[31:16]};
                    default: o_data = {i_rt[31:8],  i_raw[31:24]};
                endcase
            end
`endif
            default: o_data = ZERO_WORD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : MEM pipeline stage. Drives the data-memory request/response
//               bus, formats store lanes, aligns load data, flags AdEL/AdES
//               and stalls the pipeline until the transaction finishes.
//               Define UNALIGNED_LR_EN to implement LWL/LWR/SWL/SWR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        i_stall,
    input  logic [3:0]  i_mem_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_d1,
    input  logic [4:0]  i_rn,
    input  logic        i_write_regfile,
    input  logic        i_mem_to_regfile,
    input  logic        i_mtc0_we,
    input  logic [4:0]  i_c0_addr,
    input  logic [6:0]  i_except,
    input  logic        i_bd,
    input  logic        i_eret,
    input  logic [31:0] i_c0_wdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_req,
    output logic [31:0] o_d1,
    output logic [31:0] o_d2,
    output logic [4:0]  o_rn,
    output logic        o_write_regfile,
    output logic        o_mem_to_regfile,
    output logic        o_mtc0_we,
    output logic [4:0]  o_c0_addr,
    output logic [6:0]  o_except,
    output logic        o_bd,
    output logic        o_eret,
    output logic [31:0] o_c0_wdata,
    output logic [31:0] o_badvaddr
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WAIT_ADDR = 3'd1;
    localparam logic [2:0] c_WAIT_DATA = 3'd2;
    localparam logic [2:0] c_DONE      = 3'd3;
    localparam logic [2:0] c_CANCEL    = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_rdata_q;
    logic        w_capture;
    logic        w_req;
    logic        w_stall_req;

    logic        w_is_mem;
    logic        w_adel;
    logic        w_ades;
    logic        w_fault;
    logic        w_kill;
    logic        w_start;
    logic [6:0]  w_new_exc;

    logic        w_wr;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_addr;
    logic [31:0] w_aligned;

`ifdef UNALIGNED_LR_EN
    assign w_is_mem = (i_mem_op >= MEM_OP_LB) && (i_mem_op <= MEM_OP_SWR);
`else
    assign w_is_mem = (i_mem_op >= MEM_OP_LB) && (i_mem_op <= MEM_OP_SW);
`endif

    assign w_adel  = (((i_mem_op == MEM_OP_LH) || (i_mem_op == MEM_OP_LHU)) && i_addr[0])
                   || ((i_mem_op == MEM_OP_LW) && (i_addr[1:0] != 2'b00));
    assign w_ades  = ((i_mem_op == MEM_OP_SH) && i_addr[0])
                   || ((i_mem_op == MEM_OP_SW) && (i_addr[1:0] != 2'b00));
    assign w_fault = w_adel | w_ades;
    assign w_kill  = (i_except != 7'd0) | w_fault | i_eret;
    assign w_start = w_is_mem & ~w_kill & ~flush;

    // Exception bits raised by this stage
    always_comb begin
        w_new_exc           = 7'd0;
        w_new_exc[EXC_ADEL] = w_adel;
        w_new_exc[EXC_ADES] = w_ades;
    end

    // Request size, byte strobes, store lane replication and bus address
    always_comb begin
        w_wr    = 1'b0;
        w_size  = 2'd2;
        w_wstrb = 4'b0000;
        w_wdata = i_wdata;
        w_addr  = i_addr;
        case (i_mem_op)
            MEM_OP_LB, MEM_OP_LBU: w_size = 2'd0;
            MEM_OP_LH, MEM_OP_LHU: w_size = 2'd1;
            MEM_OP_SB: begin
                w_wr    = 1'b1;
                w_size  = 2'd0;
                w_wstrb = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            MEM_OP_SH: begin
                w_wr    = 1'b1;
                w_size  = 2'd1;
                w_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            MEM_OP_SW: begin
                w_wr    = 1'b1;
                w_wstrb = 4'b1111;
            end
`ifdef UNALIGNED_LR_EN
            MEM_OP_LWL, MEM_OP_LWR: w_addr = {i_addr[31:2], 2'b00};
            MEM_OP_SWL: begin
                w_wr   = 1'b1;
                w_addr = {i_addr[31:2], 2'b00};
                case (i_addr[1:0])
                    2'd0:    begin w_wstrb = 4'b0001; w_wdata = {24'h0, i_wdata[31:24]}; end
                    2'd1:    begin w_wstrb = 4'b0011; w_wdata = {16'h0, i_wdata[31:16]}; end
                    2'd2:    begin w_wstrb = 4'b0111; w_wdata = {8'h0,  i_wdata[31:8]};  end
                    default: begin w_wstrb = 4'b1111; w_wdata = i_wdata;                 end
                endcase
            end
            MEM_OP_SWR: begin
                w_wr   = 1'b1;
                w_addr = {i_addr[31:2], 2'b00};
                case (i_addr[1:0])
                    2'd0:    begin w_wstrb = 4'b1111; w_wdata = i_wdata;                 end
                    2'd1:    begin w_wstrb = 4'b1110; w_wdata = {i_wdata[23:0], 8'h0};  end
                    2'd2:    begin w_wstrb = 4'b1100; w_wdata = {i_wdata[15:0], 16'h0}; end
                    default: begin w_wstrb = 4'b1000; w_wdata = {i_wdata[7:0],  24'h0}; end
                endcase
            end
`endif
            default: ;
        endcase
    end

    // Transaction FSM: next state, bus request and pipeline stall
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_stall_req  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_req        = 1'b1;
                    w_stall_req  = 1'b1;
                    w_next_state = data_addr_ok ? c_WAIT_DATA : c_WAIT_ADDR;
                end
            end
            c_WAIT_ADDR: begin
                w_stall_req = 1'b1;
                if (flush) begin
                    w_next_state = c_IDLE;
                end else begin
                    w_req = 1'b1;
                    if (data_addr_ok) w_next_state = c_WAIT_DATA;
                end
            end
            c_WAIT_DATA: begin
                w_stall_req = 1'b1;
                // A response landing with the flush is simply dropped
                if (data_data_ok) begin
                    w_capture    = ~flush;
                    w_next_state = flush ? c_IDLE : c_DONE;
                end else if (flush) begin
                    w_next_state = c_CANCEL;
                end
            end
            c_DONE: begin
                if (flush || !i_stall) w_next_state = c_IDLE;
            end
            c_CANCEL: begin
                w_stall_req = 1'b1;
                if (data_data_ok) w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // State register and captured response word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_rdata_q <= ZERO_WORD;
        end else begin
            r_state <= w_next_state;
            if (w_capture) r_rdata_q <= data_rdata;
        end
    end

    mem_load_align u_load_align (
        .i_op     (i_mem_op),
        .i_offset (i_addr[1:0]),
        .i_raw    (r_rdata_q),
        .i_rt     (i_wdata),
        .o_data   (w_aligned)
    );

    assign data_req         = ~reset & w_req;
    assign data_wr          = ~reset & w_wr;
    assign data_size        = reset ? 2'd0 : w_size;
    assign data_wstrb       = reset ? 4'd0 : w_wstrb;
    assign data_addr        = reset ? ZERO_WORD : w_addr;
    assign data_wdata       = reset ? ZERO_WORD : w_wdata;
    assign stall_req        = ~reset & w_stall_req;

    assign o_d1             = reset ? ZERO_WORD : i_d1;
    assign o_d2             = (!reset && r_state == c_DONE) ? w_aligned : ZERO_WORD;
    assign o_rn             = reset ? 5'd0 : i_rn;
    assign o_write_regfile  = ~reset & ~flush & ~w_kill & i_write_regfile;
    assign o_mem_to_regfile = ~reset & i_mem_to_regfile;
    assign o_mtc0_we        = ~reset & ~flush & i_mtc0_we;
    assign o_c0_addr        = reset ? 5'd0 : i_c0_addr;
    assign o_except         = (reset || flush) ? 7'd0 : (i_except | w_new_exc);
    assign o_bd             = ~reset & i_bd;
    assign o_eret           = ~reset & i_eret;
    assign o_c0_wdata       = reset ? ZERO_WORD : i_c0_wdata;
    assign o_badvaddr       = (!reset && w_fault) ? i_addr : ZERO_WORD;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access with a behavioural
//               reference model and a bench-driven memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    localparam int ADEL_BIT = 4;
    localparam int ADES_BIT = 5;

    logic        clk = 1'b0;
    logic        reset, flush, i_stall;
    logic [3:0]  i_mem_op;
    logic [31:0] i_addr, i_wdata, i_d1, i_c0_wdata;
    logic [4:0]  i_rn, i_c0_addr;
    logic        i_write_regfile, i_mem_to_regfile, i_mtc0_we, i_bd, i_eret;
    logic [6:0]  i_except;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_req;
    logic [31:0] o_d1, o_d2, o_c0_wdata, o_badvaddr;
    logic [4:0]  o_rn, o_c0_addr;
    logic        o_write_regfile, o_mem_to_regfile, o_mtc0_we, o_bd, o_eret;
    logic [6:0]  o_except;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .reset(reset), .flush(flush), .i_stall(i_stall),
        .i_mem_op(i_mem_op), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_d1(i_d1), .i_rn(i_rn), .i_write_regfile(i_write_regfile),
        .i_mem_to_regfile(i_mem_to_regfile), .i_mtc0_we(i_mtc0_we),
        .i_c0_addr(i_c0_addr), .i_except(i_except), .i_bd(i_bd),
        .i_eret(i_eret), .i_c0_wdata(i_c0_wdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .stall_req(stall_req),
        .o_d1(o_d1), .o_d2(o_d2), .o_rn(o_rn), .o_write_regfile(o_write_regfile),
        .o_mem_to_regfile(o_mem_to_regfile), .o_mtc0_we(o_mtc0_we),
        .o_c0_addr(o_c0_addr), .o_except(o_except), .o_bd(o_bd),
        .o_eret(o_eret), .o_c0_wdata(o_c0_wdata), .o_badvaddr(o_badvaddr)
    );

    // Reference load result from byte arithmetic on the memory word
    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] m, input logic [31:0] rt);
        int k;
        logic [31:0] b, h;
        k = int'(off);
        b = (m >> (8 * k)) & 32'hFF;
        h = (m >> (16 * (k / 2))) & 32'hFFFF;
        case (op)
            4'd1: return (b >= 32'd128) ? b - 32'd256 : b;
            4'd2: return b;
            4'd3: return (h >= 32'd32768) ? h - 32'd65536 : h;
            4'd4: return h;
            4'd5: return m;
`ifdef UNALIGNED_LR_EN
            4'd9:  return (m << (8 * (3 - k))) | (rt & (32'hFFFF_FFFF >> (8 * (k + 1))));
            4'd10: return (m >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle_inputs();
        i_mem_op = 4'd0; i_addr = 32'h0; i_wdata = 32'h0; flush = 1'b0; i_stall = 1'b0;
        i_d1 = 32'h0; i_rn = 5'd0; i_write_regfile = 1'b0; i_mem_to_regfile = 1'b0;
        i_mtc0_we = 1'b0; i_c0_addr = 5'd0; i_except = 7'd0; i_bd = 1'b0; i_eret = 1'b0;
        i_c0_wdata = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    endtask

    // One complete operation: issue, responder latencies ad/dd, DONE hold, return to idle
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] mem, input int ad, input int dd, input int hold,
                          input logic [6:0] exc_in, input logic eret_in, output int stall_cnt);
        logic        valid, is_store, fault_l, fault_s, kill;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata, exp_addr, exp_d2, exp_badv;
        logic [6:0]  exp_exc;
        int k;
        k = int'(addr[1:0]);
        exp_size = 2'd2; exp_wstrb = 4'd0; exp_wdata = rt; exp_addr = addr; is_store = 1'b0;
        valid = (op >= 4'd1 && op <= 4'd8);
`ifdef UNALIGNED_LR_EN
        valid = (op >= 4'd1 && op <= 4'd12);
        if (op >= 4'd9) exp_addr = addr & 32'hFFFF_FFFC;
`endif
        case (op)
            4'd1, 4'd2: exp_size = 2'd0;
            4'd3, 4'd4: exp_size = 2'd1;
            4'd6: begin exp_size = 2'd0; is_store = 1'b1; exp_wstrb = 4'(1 << k);
                        exp_wdata = (rt & 32'hFF) * 32'h0101_0101; end
            4'd7: begin exp_size = 2'd1; is_store = 1'b1; exp_wstrb = 4'(3 << k);
                        exp_wdata = (rt & 32'hFFFF) * 32'h0001_0001; end
            4'd8: begin is_store = 1'b1; exp_wstrb = 4'hF; end
`ifdef UNALIGNED_LR_EN
            4'd11: begin is_store = 1'b1; exp_wstrb = 4'((1 << (k + 1)) - 1);
                         exp_wdata = rt >> (8 * (3 - k)); end
            4'd12: begin is_store = 1'b1; exp_wstrb = 4'((15 << k) & 15);
                         exp_wdata = rt << (8 * k); end
`endif
            default: ;
        endcase
        fault_l  = ((op == 4'd3 || op == 4'd4) && addr[0]) || (op == 4'd5 && addr[1:0] != 2'b00);
        fault_s  = (op == 4'd7 && addr[0]) || (op == 4'd8 && addr[1:0] != 2'b00);
        kill     = (exc_in != 7'd0) || fault_l || fault_s || eret_in;
        exp_exc  = exc_in | (7'(fault_l) << ADEL_BIT) | (7'(fault_s) << ADES_BIT);
        exp_badv = (fault_l || fault_s) ? addr : 32'h0;
        exp_d2   = ref_load(op, addr[1:0], mem, rt);
        stall_cnt = 0;

        @(negedge clk);
        i_mem_op = op; i_addr = addr; i_wdata = rt; i_stall = 1'b0; flush = 1'b0;
        i_d1 = $urandom; i_rn = 5'($urandom); i_write_regfile = 1'b1;
        i_mem_to_regfile = 1'($urandom); i_mtc0_we = 1'($urandom); i_c0_addr = 5'($urandom);
        i_except = exc_in; i_bd = 1'($urandom); i_eret = eret_in; i_c0_wdata = $urandom;
        data_addr_ok = (ad == 0); data_data_ok = 1'b0; data_rdata = $urandom;
        #1;
        checks++;
        if ({o_except, o_badvaddr} !== {exp_exc, exp_badv}) begin
            errors++;
            $display("FAIL except_badv op=%0d addr=%h got=%h/%h exp=%h/%h",
                     op, addr, o_except, o_badvaddr, exp_exc, exp_badv);
        end
        checks++;
        if ({o_d1, o_rn, o_write_regfile, o_mem_to_regfile, o_mtc0_we, o_c0_addr, o_bd, o_eret, o_c0_wdata}
            !== {i_d1, i_rn, !kill, i_mem_to_regfile, i_mtc0_we, i_c0_addr, i_bd, i_eret, i_c0_wdata}) begin
            errors++;
            $display("FAIL passthrough op=%0d got wr_rf=%b d1=%h exp wr_rf=%b d1=%h",
                     op, o_write_regfile, o_d1, !kill, i_d1);
        end
        if (!valid || kill) begin
            checks++;
            if ({data_req, stall_req, o_d2} !== {1'b0, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL no_request op=%0d got req=%b stall=%b d2=%h exp 0/0/0",
                         op, data_req, stall_req, o_d2);
            end
            return;
        end
        checks++;
        if ({data_wr, data_size, data_wstrb, data_addr} !== {is_store, exp_size, exp_wstrb, exp_addr}
            || (is_store && data_wdata !== exp_wdata)) begin
            errors++;
            $display("FAIL bus_fields op=%0d got wr=%b size=%0d strb=%b addr=%h wdata=%h exp %b %0d %b %h %h",
                     op, data_wr, data_size, data_wstrb, data_addr, data_wdata,
                     is_store, exp_size, exp_wstrb, exp_addr, exp_wdata);
        end
        for (int t = 0; t <= ad + dd; t++) begin
            if (t > 0) begin
                @(negedge clk);
                data_addr_ok = (t == ad);
                data_data_ok = (t == ad + dd);
                data_rdata   = (t == ad + dd) ? mem : $urandom;
                #1;
            end
            checks++;
            if ({data_req, stall_req} !== {(t <= ad), 1'b1}) begin
                errors++;
                $display("FAIL handshake op=%0d t=%0d got req=%b stall=%b exp req=%b stall=1",
                         op, t, data_req, stall_req, (t <= ad));
            end
            if (stall_req === 1'b1) stall_cnt++;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
            i_stall = (h < hold);
            #1;
            checks++;
            if ({data_req, stall_req, o_d2} !== {1'b0, 1'b0, exp_d2}) begin
                errors++;
                $display("FAIL done_data op=%0d h=%0d got req=%b stall=%b d2=%h exp 0/0/%h",
                         op, h, data_req, stall_req, o_d2, exp_d2);
            end
        end
        @(negedge clk);
        i_mem_op = 4'd0; i_stall = 1'b0; i_except = 7'd0; i_eret = 1'b0;
        #1;
        checks++;
        if ({data_req, stall_req, o_d2} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL back_to_idle op=%0d got req=%b stall=%b d2=%h exp 0/0/0",
                     op, data_req, stall_req, o_d2);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        i_mem_op = 4'd5; i_addr = 32'h0000_1001; i_wdata = 32'hFFFF_FFFF; i_d1 = 32'hFFFF_FFFF;
        i_rn = 5'h1F; i_write_regfile = 1'b1; i_mem_to_regfile = 1'b1; i_mtc0_we = 1'b1;
        i_c0_addr = 5'h1F; i_except = 7'h7F; i_bd = 1'b1; i_eret = 1'b1; i_c0_wdata = 32'hFFFF_FFFF;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, stall_req, o_d1, o_d2,
             o_rn, o_write_regfile, o_mem_to_regfile, o_mtc0_we, o_c0_addr, o_except, o_bd, o_eret,
             o_c0_wdata, o_badvaddr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b stall=%b d1=%h badv=%h exc=%h exp all zero",
                     data_req, stall_req, o_d1, o_badvaddr, o_except);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if ({data_req, stall_req, o_d2} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_idle got req=%b stall=%b d2=%h exp 0/0/0", data_req, stall_req, o_d2);
        end
    endtask

    task automatic test_lb_lbu();
        int sc;
        run_op(4'd1, 32'h0000_2003, 32'h0, 32'h80FF_FF12, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd2, 32'h0000_2003, 32'h0, 32'h80FF_FF12, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd3, 32'h0000_2002, 32'h0, 32'h9A00_0000, 1, 2, 0, 7'd0, 1'b0, sc);
    endtask

    task automatic test_sh();
        int sc;
        run_op(4'd7, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd6, 32'h0000_3001, 32'h1234_ABCD, 32'h0, 0, 2, 0, 7'd0, 1'b0, sc);
    endtask

    task automatic test_addr_error();
        int sc;
        run_op(4'd5, 32'h0000_4001, 32'h0, 32'h0, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd8, 32'h0000_4002, 32'h5555_AAAA, 32'h0, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd4, 32'h0000_4003, 32'h0, 32'h0, 0, 1, 0, 7'd0, 1'b0, sc);
    endtask

    task automatic test_delayed_lw();
        int sc;
        run_op(4'd5, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 2, 2, 3, 7'd0, 1'b0, sc);
        checks++;
        if (sc != 5) begin
            errors++;
            $display("FAIL stall_cycles got=%0d exp=5", sc);
        end
    endtask

    task automatic test_flush_cancel();
        int sc;
        @(negedge clk);
        idle_inputs();
        i_mem_op = 4'd5; i_addr = 32'h0000_0100; i_write_regfile = 1'b1; data_addr_ok = 1'b1;
        #1;
        @(negedge clk);
        data_addr_ok = 1'b0; flush = 1'b1; i_mtc0_we = 1'b1; i_except = 7'h01;
        #1;
        checks++;
        if ({o_write_regfile, o_mtc0_we, o_except, data_req, stall_req} !== {1'b0, 1'b0, 7'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_outputs got wr=%b mtc0=%b exc=%h req=%b stall=%b exp 0/0/0/0/1",
                     o_write_regfile, o_mtc0_we, o_except, data_req, stall_req);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({data_req, stall_req} !== 2'b01) begin
            errors++;
            $display("FAIL cancel_wait got req=%b stall=%b exp 0/1", data_req, stall_req);
        end
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({data_req, stall_req} !== 2'b01) begin
            errors++;
            $display("FAIL cancel_drop got req=%b stall=%b exp 0/1", data_req, stall_req);
        end
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        checks++;
        if ({data_req, stall_req, o_d2} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL cancel_exit got req=%b stall=%b d2=%h exp 0/0/0", data_req, stall_req, o_d2);
        end
        run_op(4'd5, 32'h0000_0200, 32'h0, 32'h1122_3344, 0, 1, 0, 7'd0, 1'b0, sc);
    endtask

    task automatic test_unaligned();
        int sc;
`ifdef UNALIGNED_LR_EN
        run_op(4'd9,  32'h0000_6001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd10, 32'h0000_6002, 32'h1122_3344, 32'hAABB_CCDD, 1, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd11, 32'h0000_6001, 32'h1122_3344, 32'h0, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd12, 32'h0000_6003, 32'h1122_3344, 32'h0, 0, 1, 0, 7'd0, 1'b0, sc);
`else
        run_op(4'd9,  32'h0000_6001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 7'd0, 1'b0, sc);
        run_op(4'd12, 32'h0000_6003, 32'h1122_3344, 32'h0, 0, 1, 0, 7'd0, 1'b0, sc);
`endif
    endtask

    task automatic test_random();
        int sc, r;
        logic [3:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
`ifdef UNALIGNED_LR_EN
            op = 4'($urandom_range(1, 12));
`else
            op = 4'($urandom_range(1, 8));
`endif
            addr = $urandom;
            r = int'($urandom_range(0, 3));
            if (r != 0) begin
                if (op == 4'd5 || op == 4'd8) addr[1:0] = 2'b00;
                else if (op == 4'd3 || op == 4'd4 || op == 4'd7) addr[0] = 1'b0;
            end
            run_op(op, addr, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0) ? 7'h01 : 7'h00,
                   ($urandom_range(0, 9) == 0), sc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_lbu();
        test_sh();
        test_addr_error();
        test_delayed_lw();
        test_flush_cancel();
        test_unaligned();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
